// File: rtl/id_pkg.sv
// Shared decode definitions: opcode values, opcode classes, operand/writer predicates,
// packet field offsets and the decode FSM state type.
package id_pkg;

    localparam int OPC_W_C = 5;
    typedef logic [OPC_W_C-1:0] opcode_t;

    localparam opcode_t OP_MOV            = 5'h00;
    localparam opcode_t OP_ADD            = 5'h01;
    localparam opcode_t OP_SUB            = 5'h02;
    localparam opcode_t OP_AND            = 5'h03;
    localparam opcode_t OP_OR             = 5'h04;
    localparam opcode_t OP_NOT            = 5'h05;
    localparam opcode_t OP_CMP            = 5'h06;
    localparam opcode_t OP_MULT           = 5'h07;
    localparam opcode_t OP_DIV            = 5'h08;
    localparam opcode_t OP_MOVE_LEFT      = 5'h09;
    localparam opcode_t OP_MOVE_RIGHT     = 5'h0A;
    localparam opcode_t OP_STOP           = 5'h0B;
    localparam opcode_t OP_CONTINUE       = 5'h0C;
    localparam opcode_t OP_OB_CHECK       = 5'h0D;
    localparam opcode_t OP_VELOCITY_GUARD = 5'h0E;

    typedef enum logic [1:0] {
        CLS_ALU     = 2'd0,
        CLS_MOTION  = 2'd1,
        CLS_GUARD   = 2'd2,
        CLS_ILLEGAL = 2'd3
    } opc_class_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        SEND   = 2'd2,
        GAP    = 2'd3
    } state_t;

    function automatic opc_class_t opc_class(input opcode_t opc);
        case (opc)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_NOT, OP_CMP, OP_MULT, OP_DIV:              return CLS_ALU;
            OP_MOVE_LEFT, OP_MOVE_RIGHT, OP_STOP,
            OP_CONTINUE:                                  return CLS_MOTION;
            OP_OB_CHECK, OP_VELOCITY_GUARD:               return CLS_GUARD;
            default:                                      return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic opc_reads(input opcode_t opc);
        return (opc_class(opc) == CLS_ALU) || (opc_class(opc) == CLS_GUARD);
    endfunction

    // CMP only sets flags downstream, so it never owns its rd
    function automatic logic opc_writes(input opcode_t opc);
        return (opc_class(opc) == CLS_ALU) && (opc != OP_CMP);
    endfunction

    function automatic int pkt_rd_lsb();
        return 0;
    endfunction

    function automatic int pkt_opc_lsb(input int addr_w);
        return addr_w;
    endfunction

    function automatic int pkt_opa_lsb(input int addr_w, input int opc_w);
        return addr_w + opc_w;
    endfunction

    function automatic int pkt_opb_lsb(input int addr_w, input int opc_w, input int data_w);
        return addr_w + opc_w + data_w;
    endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: flop array, synchronous write, two combinational write-first read ports.
module id_regfile
    import id_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] regs_r [NUM_REGS];

    // Write port with synchronous clear of the whole array
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en) begin
            regs_r[wr_addr] <= wr_data;
        end else begin
            regs_r[wr_addr] <= regs_r[wr_addr];
        end
    end

    // Read ports forward same-cycle write data
    always_comb begin
        rd_data_a = regs_r[rd_addr_a];
        rd_data_b = regs_r[rd_addr_b];
        if (wr_en && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end else begin
            rd_data_a = regs_r[rd_addr_a];
        end
        if (wr_en && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end else begin
            rd_data_b = regs_r[rd_addr_b];
        end
    end

endmodule

// File: rtl/id_decode_stage.sv
// Decode stage: captures an instruction from fetch, stalls on scoreboard hazards,
// reads operands and hands a packed {opB, opA, opcode, rd} word to execute.
module id_decode_stage
    import id_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int OPC_W    = 5,
    parameter int INSTR_W  = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             instr_req,
    output logic                             instr_ack,
    input  logic [INSTR_W-1:0]               instruction,
    input  logic [DATA_W-1:0]                WB_data,
    input  logic [ADDR_W-1:0]                WB_reg_addr,
    input  logic                             WB_reg_write,
    output logic                             req,
    input  logic                             ack,
    output logic [2*DATA_W+OPC_W+ADDR_W-1:0] handshake_data,
    output logic                             illegal,
    output logic [NUM_REGS-1:0]              pending
);

    localparam int USED_W      = OPC_W + 3 * ADDR_W;
    localparam int REST_W      = INSTR_W - USED_W;
    localparam int PKT_W       = 2 * DATA_W + OPC_W + ADDR_W;
    localparam int PKT_RD_LSB  = pkt_rd_lsb();
    localparam int PKT_OPC_LSB = pkt_opc_lsb(ADDR_W);
    localparam int PKT_OPA_LSB = pkt_opa_lsb(ADDR_W, OPC_W);
    localparam int PKT_OPB_LSB = pkt_opb_lsb(ADDR_W, OPC_W, DATA_W);

    state_t              state_r, state_n;
    logic [USED_W-1:0]   instr_r;
    logic                capture_s;
    logic                req_r, req_n;
    logic                instr_ack_r, instr_ack_n;
    logic                illegal_r, illegal_n;
    logic [PKT_W-1:0]    hs_r, hs_n;
    logic [NUM_REGS-1:0] pending_r, pending_n;
    logic [NUM_REGS-1:0] wb_mask_s, set_mask_s, pend_eff_s;

    logic [OPC_W-1:0]    opc_s;
    logic [ADDR_W-1:0]   rd_s, rs1_s, rs2_s;
    opc_class_t          cls_s;
    logic                reads_s, writes_s, hazard_s;
    logic [DATA_W-1:0]   opa_s, opb_s;
    logic                unused_rest_s;

    assign unused_rest_s = ^instruction[REST_W-1:0];

    assign opc_s = instr_r[USED_W-1 -: OPC_W];
    assign rd_s  = instr_r[3*ADDR_W-1 -: ADDR_W];
    assign rs1_s = instr_r[2*ADDR_W-1 -: ADDR_W];
    assign rs2_s = instr_r[ADDR_W-1:0];

    assign cls_s    = opc_class(opcode_t'(opc_s));
    assign reads_s  = opc_reads(opcode_t'(opc_s));
    assign writes_s = opc_writes(opcode_t'(opc_s));

    id_regfile #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (WB_reg_write),
        .wr_addr   (WB_reg_addr),
        .wr_data   (WB_data),
        .rd_addr_a (rs1_s),
        .rd_data_a (opa_s),
        .rd_addr_b (rs2_s),
        .rd_data_b (opb_s)
    );

    // A write-back landing this cycle releases its pending bit for the hazard check
    assign wb_mask_s  = WB_reg_write ? (NUM_REGS'(1) << WB_reg_addr) : '0;
    assign pend_eff_s = pending_r & ~wb_mask_s;
    assign hazard_s   = (reads_s && (pend_eff_s[rs1_s] || pend_eff_s[rs2_s]))
                     || (writes_s && pend_eff_s[rd_s]);
    assign pending_n  = (pending_r & ~wb_mask_s) | set_mask_s;

    // Next-state and next-output logic
    always_comb begin
        state_n     = state_r;
        req_n       = req_r;
        instr_ack_n = 1'b0;
        illegal_n   = 1'b0;
        hs_n        = hs_r;
        set_mask_s  = '0;
        capture_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (instr_req) begin
                    capture_s   = 1'b1;
                    instr_ack_n = 1'b1;
                    state_n     = DECODE;
                end else begin
                    state_n = IDLE;
                end
            end
            DECODE: begin
                if (cls_s == CLS_ILLEGAL) begin
                    illegal_n = 1'b1;
                    state_n   = IDLE;
                end else if (hazard_s) begin
                    state_n = DECODE;
                end else begin
                    hs_n[PKT_RD_LSB  +: ADDR_W] = rd_s;
                    hs_n[PKT_OPC_LSB +: OPC_W]  = opc_s;
                    hs_n[PKT_OPA_LSB +: DATA_W] = reads_s ? opa_s : '0;
                    hs_n[PKT_OPB_LSB +: DATA_W] = reads_s ? opb_s : '0;
                    set_mask_s = writes_s ? (NUM_REGS'(1) << rd_s) : '0;
                    req_n      = 1'b1;
                    state_n    = SEND;
                end
            end
            SEND: begin
                if (ack) begin
                    req_n   = 1'b0;
                    state_n = GAP;
                end else begin
                    state_n = SEND;
                end
            end
            GAP: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
            default: begin
                req_n   = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, registered outputs, scoreboard and instruction latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            req_r       <= 1'b0;
            instr_ack_r <= 1'b0;
            illegal_r   <= 1'b0;
            hs_r        <= '0;
            pending_r   <= '0;
            instr_r     <= '0;
        end else begin
            state_r     <= state_n;
            req_r       <= req_n;
            instr_ack_r <= instr_ack_n;
            illegal_r   <= illegal_n;
            hs_r        <= hs_n;
            pending_r   <= pending_n;
            if (capture_s) begin
                instr_r <= instruction[INSTR_W-1 -: USED_W];
            end else begin
                instr_r <= instr_r;
            end
        end
    end

    assign req            = req_r;
    assign instr_ack      = instr_ack_r;
    assign illegal        = illegal_r;
    assign handshake_data = hs_r;
    assign pending        = pending_r;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: vector table plus hand sequences for stall, ack hold and reset.
module tb_id_decode_stage;
    import id_pkg::*;

    localparam int DATA_W = 16, NUM_REGS = 16, ADDR_W = 4, OPC_W = 5, INSTR_W = 32;
    localparam int PKT_W  = 2 * DATA_W + OPC_W + ADDR_W;

    logic               clk, reset, instr_req, instr_ack, WB_reg_write, req, ack, illegal;
    logic [INSTR_W-1:0] instruction;
    logic [DATA_W-1:0]  WB_data;
    logic [ADDR_W-1:0]  WB_reg_addr;
    logic [PKT_W-1:0]   handshake_data;
    logic [NUM_REGS-1:0] pending;

    id_decode_stage #(
        .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .OPC_W(OPC_W), .INSTR_W(INSTR_W)
    ) u_dut (
        .clk(clk), .reset(reset), .instr_req(instr_req), .instr_ack(instr_ack),
        .instruction(instruction), .WB_data(WB_data), .WB_reg_addr(WB_reg_addr),
        .WB_reg_write(WB_reg_write), .req(req), .ack(ack), .handshake_data(handshake_data),
        .illegal(illegal), .pending(pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  opc;
        logic [3:0]  rd, rs1, rs2;
        logic        ill;
        logic [15:0] opa, opb;
        logic [15:0] pend;
    } vec_t;

    vec_t             vecs[10];
    logic [PKT_W-1:0] exp_q[$];
    int               total = 0;
    int               bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [INSTR_W-1:0] mk(input logic [4:0] opc, input logic [3:0] rd,
                                              input logic [3:0] rs1, input logic [3:0] rs2);
        logic [14:0] rest;
        rest = 15'($urandom);
        return {opc, rd, rs1, rs2, rest};
    endfunction

    function automatic logic [PKT_W-1:0] pkt(input logic [15:0] opb, input logic [15:0] opa,
                                             input logic [4:0] opc, input logic [3:0] rd);
        return {opb, opa, opc, rd};
    endfunction

    task automatic pop_chk(input string name);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0h expected <empty scoreboard>", name, handshake_data);
        end else begin
            chk(name, 64'(handshake_data), 64'(exp_q.pop_front()));
        end
    endtask

    task automatic wb(input logic [3:0] addr, input logic [15:0] data);
        WB_reg_addr  = addr;
        WB_data      = data;
        WB_reg_write = 1'b1;
        tick();
        WB_reg_write = 1'b0;
    endtask

    // Issue one instruction from IDLE with ack held high; returns in IDLE
    task automatic run_vec(input int idx, input vec_t v);
        if (!v.ill) exp_q.push_back(pkt(v.opb, v.opa, v.opc, v.rd));
        instruction = mk(v.opc, v.rd, v.rs1, v.rs2);
        instr_req   = 1'b1;
        tick();
        chk($sformatf("v%0d instr_ack", idx), 64'(instr_ack), 64'd1);
        chk($sformatf("v%0d req_in_decode", idx), 64'(req), 64'd0);
        instr_req   = 1'b0;
        instruction = $urandom;
        tick();
        if (v.ill) begin
            chk($sformatf("v%0d illegal", idx), 64'(illegal), 64'd1);
            chk($sformatf("v%0d req_illegal", idx), 64'(req), 64'd0);
            chk($sformatf("v%0d pending", idx), 64'(pending), 64'(v.pend));
            tick();
            chk($sformatf("v%0d illegal_width", idx), 64'(illegal), 64'd0);
        end else begin
            chk($sformatf("v%0d req", idx), 64'(req), 64'd1);
            pop_chk($sformatf("v%0d data", idx));
            chk($sformatf("v%0d pending", idx), 64'(pending), 64'(v.pend));
            chk($sformatf("v%0d instr_ack_width", idx), 64'(instr_ack), 64'd0);
            tick();
            chk($sformatf("v%0d req_gap", idx), 64'(req), 64'd0);
            tick();
        end
    endtask

    initial begin
        logic [PKT_W-1:0] held;
        vecs[0] = '{OP_ADD,            4'd1,  4'd2, 4'd3, 1'b0, 16'd5,     16'd7,     16'h0002};
        vecs[1] = '{OP_MOVE_LEFT,      4'd9,  4'd1, 4'd1, 1'b0, 16'd0,     16'd0,     16'h0002};
        vecs[2] = '{OP_CMP,            4'd2,  4'd5, 4'd6, 1'b0, 16'h1234,  16'hABCD,  16'h0002};
        vecs[3] = '{OP_OB_CHECK,       4'd1,  4'd6, 4'd5, 1'b0, 16'hABCD,  16'h1234,  16'h0002};
        vecs[4] = '{5'h1F,             4'd1,  4'd1, 4'd1, 1'b1, 16'd0,     16'd0,     16'h0002};
        vecs[5] = '{OP_MOV,            4'd7,  4'd5, 4'd0, 1'b0, 16'h1234,  16'd0,     16'h0082};
        vecs[6] = '{OP_DIV,            4'd8,  4'd3, 4'd2, 1'b0, 16'd7,     16'd5,     16'h0182};
        vecs[7] = '{5'h0F,             4'd8,  4'd8, 4'd8, 1'b1, 16'd0,     16'd0,     16'h0182};
        vecs[8] = '{OP_VELOCITY_GUARD, 4'd0,  4'd3, 4'd3, 1'b0, 16'd7,     16'd7,     16'h0182};
        vecs[9] = '{OP_MULT,           4'd15, 4'd6, 4'd2, 1'b0, 16'hABCD,  16'd5,     16'h8182};

        reset = 1'b1; instr_req = 1'b0; instruction = '0; ack = 1'b1;
        WB_data = '0; WB_reg_addr = '0; WB_reg_write = 1'b0;
        tick(); tick();
        chk("reset req", 64'(req), 64'd0);
        chk("reset instr_ack", 64'(instr_ack), 64'd0);
        chk("reset illegal", 64'(illegal), 64'd0);
        chk("reset data", 64'(handshake_data), 64'd0);
        chk("reset pending", 64'(pending), 64'd0);
        reset = 1'b0;
        tick();

        wb(4'd2, 16'd5); wb(4'd3, 16'd7); wb(4'd5, 16'h1234); wb(4'd6, 16'hABCD);
        chk("wb nonpending", 64'(pending), 64'd0);

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // RAW stall on r1, released by write-back of r1 with forwarding
        exp_q.push_back(pkt(16'd7, 16'd12, OP_SUB, 4'd4));
        instruction = mk(OP_SUB, 4'd4, 4'd1, 4'd3);
        instr_req = 1'b1;
        tick();
        chk("stall instr_ack", 64'(instr_ack), 64'd1);
        instr_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall req c%0d", i), 64'(req), 64'd0);
            chk($sformatf("stall pending c%0d", i), 64'(pending), 64'h8182);
        end
        wb(4'd1, 16'd12);
        chk("stall release req", 64'(req), 64'd1);
        pop_chk("stall data");
        chk("stall pending", 64'(pending), 64'h8190);
        tick();
        chk("stall gap", 64'(req), 64'd0);
        tick();

        // ack withheld in SEND for 10 cycles
        ack = 1'b0;
        exp_q.push_back(pkt(16'd5, 16'd12, OP_AND, 4'd5));
        instruction = mk(OP_AND, 4'd5, 4'd1, 4'd2);
        instr_req = 1'b1;
        tick();
        instr_req = 1'b0;
        tick();
        chk("hold req", 64'(req), 64'd1);
        held = (exp_q.size() > 0) ? exp_q[0] : '0;
        pop_chk("hold data");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("hold req c%0d", i), 64'(req), 64'd1);
            chk($sformatf("hold data c%0d", i), 64'(handshake_data), 64'(held));
        end
        ack = 1'b1;
        tick();
        chk("hold released", 64'(req), 64'd0);
        exp_q.push_back(pkt(16'd0, 16'd5, OP_NOT, 4'd10));
        instruction = mk(OP_NOT, 4'd10, 4'd2, 4'd0);
        instr_req = 1'b1;
        tick();
        chk("gap ignores instr_req", 64'(instr_ack), 64'd0);
        tick();
        chk("after gap instr_ack", 64'(instr_ack), 64'd1);
        instr_req = 1'b0;
        tick();
        chk("after gap req", 64'(req), 64'd1);
        pop_chk("after gap data");
        chk("after gap pending", 64'(pending), 64'h85B0);
        tick(); tick();

        // reset while waiting in SEND
        ack = 1'b0;
        exp_q.push_back(pkt(16'd7, 16'd5, OP_ADD, 4'd11));
        instruction = mk(OP_ADD, 4'd11, 4'd2, 4'd3);
        instr_req = 1'b1;
        tick();
        instr_req = 1'b0;
        tick();
        pop_chk("pre-reset data");
        chk("pre-reset pending", 64'(pending), 64'h8DB0);
        tick();
        chk("pre-reset req", 64'(req), 64'd1);
        reset = 1'b1;
        tick();
        chk("mid reset req", 64'(req), 64'd0);
        chk("mid reset pending", 64'(pending), 64'd0);
        chk("mid reset data", 64'(handshake_data), 64'd0);
        reset = 1'b0;
        ack = 1'b1;
        tick();
        run_vec(10, '{OP_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 16'd0, 16'd0, 16'h0002});

        chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
